rob_nway: RTL and testbench
===========================

# rob_nway

Parametrised N-wide reorder buffer, the superscalar successor to the single-wide `rob`. It sits between `stage_id` (dispatch), `stage_ic` (completion) and `stage_ir` (retire). Each cycle it accepts up to WIDTH in-order dispatches, CDB_W out-of-order completions and up to WIDTH in-order retirements. It also performs retire-time branch-mispredict recovery by squashing every younger entry.

## Interface
Parameters:
- DEPTH, 32: entries; power of two, at least 2·WIDTH.
- WIDTH, 2: dispatch and retire lanes.
- CDB_W, 2: completion ports.
- PREG_BITS, 6: physical tag width.
- AREG_BITS, 5: architectural register width.
- IDX = $clog2(DEPTH), derived localparam.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- disp_valid  in  WIDTH  per-lane dispatch request; valid lanes must form a contiguous run starting at lane 0.
- disp_dest_areg  in  WIDTH·AREG_BITS  destination arch register.
- disp_t_new  in  WIDTH·PREG_BITS  newly allocated physical tag.
- disp_t_old  in  WIDTH·PREG_BITS  previous mapping of the destination.
- disp_idx  out  WIDTH·IDX  ROB index for each lane: tail+lane mod DEPTH.
- free_slots  out  IDX+1  free entries, registered.
- cmpl_valid  in  CDB_W  completion strobe.
- cmpl_idx  in  CDB_W·IDX  index of the completing entry.
- cmpl_mispredict  in  CDB_W  completing branch was mispredicted.
- retire_valid  out  WIDTH  lane retires this cycle; asserted lanes are contiguous from lane 0.
- retire_dest_areg, retire_t_new, retire_t_old  out  WIDTH·AREG_BITS, WIDTH·PREG_BITS, WIDTH·PREG_BITS  retiring entry fields, used for the architectural map and for freeing T_old.
- squash  out  1  a mispredicted branch retires this cycle.

## Operation
- State: per-entry {valid, complete, mispredict, areg, t_new, t_old}; head and tail pointers of IDX+1 bits each, the MSB being the wrap bit; count.
- Dispatch: with k = popcount(disp_valid), write lanes 0..k−1 at tail+lane and set tail += k. Lanes with index ≥ free_slots are dropped. Upstream must never exceed free_slots; the bench asserts this. Dispatch is ignored in any squash cycle.
- Completion: sets complete, and sets mispredict from cmpl_mispredict. A completion to an entry that is not valid is ignored. Several ports targeting distinct indices all apply in the same cycle.
- Retire: scan head+0..WIDTH−1.
  - Lane i retires iff lanes 0..i−1 retired, entry i is valid and complete, and no earlier lane in this cycle carried mispredict.
  - Retire outputs are combinational from registered state. On the edge, head advances by the number retired and those entries are invalidated.
- Squash: asserted when a retiring lane has mispredict set. That branch itself retires; younger lanes in the same cycle do not. On the edge, all valid bits clear, tail := new head, count := 0, and any simultaneous completions are discarded.
- count_next = count + dispatched − retired, with squash overriding to 0. free_slots = DEPTH − count.
- Full: free_slots = 0, so all dispatch is dropped. Empty: retire_valid = 0. Pointer arithmetic wraps modulo DEPTH; the wrap bit distinguishes full from empty.
- Reset: head = tail = 0, all valid = 0, count = 0, free_slots = DEPTH, retire_valid = 0, squash = 0, disp_idx = 0..WIDTH−1.

## Timing
- Dispatch in cycle c: the entry is visible in state at c+1. disp_idx is combinational in cycle c.
- Completion in cycle c: the entry is eligible to retire in c+1. Minimum dispatch-to-retire latency is 2 cycles.
- free_slots reflects state at the start of the cycle. Same-cycle retirements are not credited until c+1.
- squash is high for exactly one cycle. The first post-squash dispatch is accepted in c+1 at index = head.
- Reset asserted mid-operation overrides dispatch, completion and squash in that cycle.

## Structure
- `ROB_ENTRY` struct, `ROB_IDX` typedef and the DEPTH/WIDTH defaults go in sys_defs.svh beside the existing packets.
- One sub-module, `rob_retire_sel`: combinational WIDTH-lane prefix selector producing retire_valid, retire count and squash from head-window complete/mispredict bits.

## Test plan
- Reset, then dispatch 2 lanes for 3 cycles (tags 32..37): disp_idx 0,1 / 2,3 / 4,5; free_slots 32→30→28→26.
- Complete idx 1 then idx 0 one cycle later: no retire until idx 0 completes; next cycle retire_valid=2'b11 with t_new 32,33.
- Fill to DEPTH with head at 30: tail wraps to 30 with wrap bit flipped; free_slots=0; further dispatch is dropped; one retire frees 1 slot.
- Dispatch branch at idx 4 plus younger idx 5–9, complete all, idx 4 with mispredict: retire lane 0 only, squash=1 for one cycle; next cycle free_slots=32 and disp_idx starts at 5.
- Dispatch and retire in the same cycle with count=DEPTH−1: dispatch of 1 accepted, 1 retired, count stays 31.
- Assert reset with 10 valid entries: the next cycle shows free_slots=32, retire_valid=0, disp_idx=0,1.

Source files
------------

// File: rtl/rob_nway_pkg.sv
// Shared defaults and per-entry status type for the N-wide reorder buffer.
package rob_nway_pkg;

   localparam int ROB_DEPTH     = 32;
   localparam int ROB_WIDTH     = 2;
   localparam int ROB_CDB_W     = 2;
   localparam int ROB_PREG_BITS = 6;
   localparam int ROB_AREG_BITS = 5;

   typedef struct packed {
      logic valid;
      logic complete;
      logic mispredict;
   } rob_status_t;

   // Bits needed to hold a lane count of 0..lanes.
   function automatic int cnt_bits(input int lanes);
      return $clog2(lanes + 1);
   endfunction

endpackage

// File: rtl/rob_nway_retire_sel.sv
// Retire-window prefix selector: picks the in-order run of completed head entries,
// stopping after the first mispredicted branch.
module rob_retire_sel
   import rob_nway_pkg::*;
#(
   parameter  int WIDTH = ROB_WIDTH,
   localparam int CW    = cnt_bits(WIDTH)
) (
   input  logic [WIDTH-1:0] win_valid,
   input  logic [WIDTH-1:0] win_complete,
   input  logic [WIDTH-1:0] win_mispredict,
   output logic [WIDTH-1:0] retire_valid,
   output logic [CW-1:0]    retire_cnt,
   output logic             squash
);

   logic go;

   always_comb begin
      retire_valid = '0;
      retire_cnt   = '0;
      squash       = 1'b0;
      go           = 1'b1;
      for (int i = 0; i < WIDTH; i++) begin
         if (go && win_valid[i] && win_complete[i]) begin
            retire_valid[i] = 1'b1;
            retire_cnt      = retire_cnt + CW'(1);
            if (win_mispredict[i]) begin
               squash = 1'b1;
               go     = 1'b0;
            end
         end else begin
            go = 1'b0;
         end
      end
   end

endmodule

// File: rtl/rob_nway.sv
// N-wide reorder buffer: in-order dispatch/retire, out-of-order completion,
// retire-time squash of everything younger than a mispredicted branch.
module rob_nway
   import rob_nway_pkg::*;
#(
   parameter  int DEPTH     = ROB_DEPTH,
   parameter  int WIDTH     = ROB_WIDTH,
   parameter  int CDB_W     = ROB_CDB_W,
   parameter  int PREG_BITS = ROB_PREG_BITS,
   parameter  int AREG_BITS = ROB_AREG_BITS,
   localparam int IDX       = $clog2(DEPTH)
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [WIDTH-1:0]           disp_valid,
   input  logic [WIDTH*AREG_BITS-1:0] disp_dest_areg,
   input  logic [WIDTH*PREG_BITS-1:0] disp_t_new,
   input  logic [WIDTH*PREG_BITS-1:0] disp_t_old,
   output logic [WIDTH*IDX-1:0]       disp_idx,
   output logic [IDX:0]               free_slots,
   input  logic [CDB_W-1:0]           cmpl_valid,
   input  logic [CDB_W*IDX-1:0]       cmpl_idx,
   input  logic [CDB_W-1:0]           cmpl_mispredict,
   output logic [WIDTH-1:0]           retire_valid,
   output logic [WIDTH*AREG_BITS-1:0] retire_dest_areg,
   output logic [WIDTH*PREG_BITS-1:0] retire_t_new,
   output logic [WIDTH*PREG_BITS-1:0] retire_t_old,
   output logic                       squash
);

   localparam int CW = cnt_bits(WIDTH);

   rob_status_t          status  [DEPTH];
   logic [AREG_BITS-1:0] areg_q  [DEPTH];
   logic [PREG_BITS-1:0] t_new_q [DEPTH];
   logic [PREG_BITS-1:0] t_old_q [DEPTH];

   logic [IDX:0]       head, tail, count;
   logic [IDX-1:0]     win_idx [WIDTH];
   logic [WIDTH-1:0]   win_valid, win_complete, win_mispredict;
   logic [WIDTH-1:0]   disp_acc;
   logic [CW-1:0]      retire_cnt, disp_cnt;
   logic               disp_run;

   assign free_slots = (IDX+1)'(DEPTH) - count;

   for (genvar g = 0; g < WIDTH; g++) begin : g_lane
      assign win_idx[g]        = head[IDX-1:0] + IDX'(g);
      assign win_valid[g]      = status[win_idx[g]].valid;
      assign win_complete[g]   = status[win_idx[g]].complete;
      assign win_mispredict[g] = status[win_idx[g]].mispredict;
      assign retire_dest_areg[g*AREG_BITS +: AREG_BITS] = areg_q[win_idx[g]];
      assign retire_t_new[g*PREG_BITS +: PREG_BITS]     = t_new_q[win_idx[g]];
      assign retire_t_old[g*PREG_BITS +: PREG_BITS]     = t_old_q[win_idx[g]];
      assign disp_idx[g*IDX +: IDX] = tail[IDX-1:0] + IDX'(g);
   end

   rob_retire_sel #(.WIDTH(WIDTH)) u_retire_sel (
      .win_valid      (win_valid),
      .win_complete   (win_complete),
      .win_mispredict (win_mispredict),
      .retire_valid   (retire_valid),
      .retire_cnt     (retire_cnt),
      .squash         (squash)
   );

   // Accept the contiguous valid run from lane 0, capped by the start-of-cycle free count.
   always_comb begin
      disp_acc = '0;
      disp_cnt = '0;
      disp_run = !squash;
      for (int i = 0; i < WIDTH; i++) begin
         disp_run    = disp_run && disp_valid[i] && ((IDX+1)'(i) < free_slots);
         disp_acc[i] = disp_run;
         if (disp_run) disp_cnt = disp_cnt + CW'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) status[i] <= '0;
      end else if (squash) begin
         for (int i = 0; i < DEPTH; i++) status[i].valid <= 1'b0;
         head  <= head + (IDX+1)'(retire_cnt);
         tail  <= head + (IDX+1)'(retire_cnt);
         count <= '0;
      end else begin
         for (int p = 0; p < CDB_W; p++) begin
            if (cmpl_valid[p] && status[cmpl_idx[p*IDX +: IDX]].valid) begin
               status[cmpl_idx[p*IDX +: IDX]].complete   <= 1'b1;
               status[cmpl_idx[p*IDX +: IDX]].mispredict <= cmpl_mispredict[p];
            end
         end
         for (int i = 0; i < WIDTH; i++) begin
            if (retire_valid[i]) status[win_idx[i]].valid <= 1'b0;
         end
         for (int i = 0; i < WIDTH; i++) begin
            if (disp_acc[i]) begin
               status[tail[IDX-1:0] + IDX'(i)]  <= '{valid: 1'b1, complete: 1'b0, mispredict: 1'b0};
               areg_q[tail[IDX-1:0] + IDX'(i)]  <= disp_dest_areg[i*AREG_BITS +: AREG_BITS];
               t_new_q[tail[IDX-1:0] + IDX'(i)] <= disp_t_new[i*PREG_BITS +: PREG_BITS];
               t_old_q[tail[IDX-1:0] + IDX'(i)] <= disp_t_old[i*PREG_BITS +: PREG_BITS];
            end
         end
         head  <= head + (IDX+1)'(retire_cnt);
         tail  <= tail + (IDX+1)'(disp_cnt);
         count <= count + (IDX+1)'(disp_cnt) - (IDX+1)'(retire_cnt);
      end
   end

endmodule

// File: tb/tb_rob_nway.sv
// Bench for rob_nway: directed scenarios plus random traffic, checked against a queue model.
module tb_rob_nway;

   localparam int D  = 32;
   localparam int W  = 2;
   localparam int C  = 2;
   localparam int PB = 6;
   localparam int AB = 5;
   localparam int IW = 5;

   logic            clock = 1'b0;
   logic            reset = 1'b1;
   logic [W-1:0]    disp_valid;
   logic [W*AB-1:0] disp_dest_areg;
   logic [W*PB-1:0] disp_t_new, disp_t_old;
   logic [W*IW-1:0] disp_idx;
   logic [IW:0]     free_slots;
   logic [C-1:0]    cmpl_valid, cmpl_mispredict;
   logic [C*IW-1:0] cmpl_idx;
   logic [W-1:0]    retire_valid;
   logic [W*AB-1:0] retire_dest_areg;
   logic [W*PB-1:0] retire_t_new, retire_t_old;
   logic            squash;

   rob_nway #(.DEPTH(D), .WIDTH(W), .CDB_W(C), .PREG_BITS(PB), .AREG_BITS(AB)) dut (
      .clock            (clock),
      .reset            (reset),
      .disp_valid       (disp_valid),
      .disp_dest_areg   (disp_dest_areg),
      .disp_t_new       (disp_t_new),
      .disp_t_old       (disp_t_old),
      .disp_idx         (disp_idx),
      .free_slots       (free_slots),
      .cmpl_valid       (cmpl_valid),
      .cmpl_idx         (cmpl_idx),
      .cmpl_mispredict  (cmpl_mispredict),
      .retire_valid     (retire_valid),
      .retire_dest_areg (retire_dest_areg),
      .retire_t_new     (retire_t_new),
      .retire_t_old     (retire_t_old),
      .squash           (squash)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [AB-1:0] areg;
      logic [PB-1:0] t_new;
      logic [PB-1:0] t_old;
      bit            comp;
      bit            misp;
   } ment_t;

   ment_t m_q[$];
   int    m_head = 0;
   int    e_n = 0;
   bit    e_sq = 1'b0;
   int    tag = 32;
   int    n_checks = 0;
   int    n_pass = 0;
   int    n_fail = 0;

   task automatic chk(input string tag_s, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag_s, obs, exp);
      end
   endtask

   task automatic clr();
      disp_valid      = '0;
      disp_dest_areg  = '0;
      disp_t_new      = '0;
      disp_t_old      = '0;
      cmpl_valid      = '0;
      cmpl_idx        = '0;
      cmpl_mispredict = '0;
   endtask

   task automatic disp(input int k);
      disp_valid = '0;
      for (int i = 0; i < k; i++) begin
         disp_valid[i]               = 1'b1;
         disp_dest_areg[i*AB +: AB]  = AB'($urandom);
         disp_t_new[i*PB +: PB]      = PB'(tag);
         disp_t_old[i*PB +: PB]      = PB'($urandom);
         tag++;
      end
   endtask

   task automatic cmpl(input int p, input int idx, input bit m);
      cmpl_valid[p]           = 1'b1;
      cmpl_idx[p*IW +: IW]    = IW'(idx);
      cmpl_mispredict[p]      = m;
   endtask

   // Expected outputs follow from the oldest-first queue: retire the leading completed
   // entries (up to W), stopping right after a mispredicted one.
   task automatic check_outputs();
      logic [W*IW-1:0] e_idx;
      logic [W-1:0]    e_rv;
      logic [W*AB-1:0] e_ar, m_ar;
      logic [W*PB-1:0] e_tn, e_to, m_p;
      int              sz;
      sz = m_q.size();
      e_n = 0; e_sq = 1'b0;
      e_idx = '0; e_rv = '0; e_ar = '0; m_ar = '0; e_tn = '0; e_to = '0; m_p = '0;
      while (e_n < W && e_n < sz && !e_sq && m_q[e_n].comp) begin
         e_sq                = m_q[e_n].misp;
         e_rv[e_n]           = 1'b1;
         e_ar[e_n*AB +: AB]  = m_q[e_n].areg;
         m_ar[e_n*AB +: AB]  = '1;
         e_tn[e_n*PB +: PB]  = m_q[e_n].t_new;
         e_to[e_n*PB +: PB]  = m_q[e_n].t_old;
         m_p[e_n*PB +: PB]   = '1;
         e_n++;
      end
      for (int i = 0; i < W; i++) e_idx[i*IW +: IW] = IW'((m_head + sz + i) % D);
      chk("free_slots",   64'(free_slots),   64'(D - sz));
      chk("disp_idx",     64'(disp_idx),     64'(e_idx));
      chk("retire_valid", 64'(retire_valid), 64'(e_rv));
      chk("squash",       64'(squash),       64'(e_sq));
      chk("retire_areg",  64'(retire_dest_areg & m_ar), 64'(e_ar));
      chk("retire_t_new", 64'(retire_t_new & m_p),      64'(e_tn));
      chk("retire_t_old", 64'(retire_t_old & m_p),      64'(e_to));
   endtask

   task automatic update_model();
      int    sz0, fr, pos;
      ment_t e;
      if (reset) begin
         m_q.delete();
         m_head = 0;
         return;
      end
      if (e_sq) begin
         m_head = (m_head + e_n) % D;
         m_q.delete();
         return;
      end
      sz0 = m_q.size();
      fr  = D - sz0;
      for (int p = 0; p < C; p++) begin
         if (cmpl_valid[p]) begin
            pos = (int'(cmpl_idx[p*IW +: IW]) - m_head + D) % D;
            if (pos < sz0) begin
               m_q[pos].comp = 1'b1;
               m_q[pos].misp = cmpl_mispredict[p];
            end
         end
      end
      for (int i = 0; i < e_n; i++) void'(m_q.pop_front());
      m_head = (m_head + e_n) % D;
      for (int i = 0; i < W; i++) begin
         if (!disp_valid[i] || i >= fr) break;
         e.areg  = disp_dest_areg[i*AB +: AB];
         e.t_new = disp_t_new[i*PB +: PB];
         e.t_old = disp_t_old[i*PB +: PB];
         e.comp  = 1'b0;
         e.misp  = 1'b0;
         m_q.push_back(e);
      end
   endtask

   // Inputs are applied at the falling edge; outputs sampled 1 time unit later.
   task automatic cyc();
      #1;
      if (!reset) check_outputs();
      @(posedge clock);
      update_model();
      @(negedge clock);
   endtask

   task automatic fill(input int n);
      int k;
      while (n > 0) begin
         k = (n >= W) ? W : n;
         clr();
         disp(k);
         cyc();
         n -= k;
      end
      clr();
   endtask

   task automatic drain();
      int p;
      for (int c = 0; c < 200 && m_q.size() > 0; c++) begin
         clr();
         p = 0;
         for (int j = 0; j < m_q.size() && p < C; j++) begin
            if (!m_q[j].comp) begin
               cmpl(p, (m_head + j) % D, 1'b0);
               p++;
            end
         end
         cyc();
      end
      clr();
      cyc();
      chk("drain_free", 64'(free_slots), 64'(D));
   endtask

   initial begin
      int sz, k, p, j, last;
      clr();
      reset = 1'b1;
      @(negedge clock);
      cyc();
      cyc();
      reset = 1'b0;
      chk("rst_free",    64'(free_slots),   64'd32);
      chk("rst_retire",  64'(retire_valid), 64'd0);
      chk("rst_squash",  64'(squash),       64'd0);
      chk("rst_idx",     64'(disp_idx),     64'h20);

      // three 2-wide dispatches, tags 32..37
      disp(2); cyc(); chk("d1_free", 64'(free_slots), 64'd30);
      disp(2); cyc(); chk("d2_free", 64'(free_slots), 64'd28);
      disp(2); cyc(); chk("d3_free", 64'(free_slots), 64'd26);
      chk("d3_idx", 64'(disp_idx), 64'((7 << IW) | 6));

      // younger completes first: nothing may retire until the head completes
      clr(); cmpl(0, 1, 1'b0); cyc();
      chk("ooo_hold", 64'(retire_valid), 64'd0);
      clr(); cmpl(0, 0, 1'b0); cyc();
      chk("ooo_rv",   64'(retire_valid), 64'b11);
      chk("ooo_tnew", 64'(retire_t_new), 64'((33 << PB) | 32));
      clr();
      drain();

      // wrap: move head to 30, then fill all 32 entries
      fill(24); drain();
      fill(32);
      chk("full_free", 64'(free_slots), 64'd0);
      chk("full_idx",  64'(disp_idx[IW-1:0]), 64'd30);
      disp(2); cyc();
      chk("drop_free", 64'(free_slots), 64'd0);
      chk("drop_idx",  64'(disp_idx[IW-1:0]), 64'd30);
      clr(); cmpl(0, 30, 1'b0); cyc();
      chk("full_rv", 64'(retire_valid), 64'b01);
      clr(); cyc();
      chk("full_credit", 64'(free_slots), 64'd1);
      drain();

      // mispredicted branch at index 4 with younger 5..9
      fill(6); drain();
      fill(6);
      cmpl(0, 5, 1'b0); cmpl(1, 6, 1'b0); cyc();
      clr(); cmpl(0, 7, 1'b0); cmpl(1, 8, 1'b0); cyc();
      clr(); cmpl(0, 9, 1'b0); cmpl(1, 4, 1'b1); cyc();
      clr();
      chk("sq_rv", 64'(retire_valid), 64'b01);
      chk("sq_on", 64'(squash), 64'd1);
      cyc();
      chk("sq_off",  64'(squash), 64'd0);
      chk("sq_free", 64'(free_slots), 64'd32);
      chk("sq_idx",  64'(disp_idx[IW-1:0]), 64'd5);

      // simultaneous dispatch and retire at count = DEPTH-1
      fill(31);
      cmpl(0, 5, 1'b0); cyc();
      clr(); disp(1); cyc();
      clr();
      chk("dr_free", 64'(free_slots), 64'd1);
      drain();

      // reset with live entries
      fill(10);
      reset = 1'b1; cyc(); reset = 1'b0;
      chk("mrst_free", 64'(free_slots),   64'd32);
      chk("mrst_rv",   64'(retire_valid), 64'd0);
      chk("mrst_idx",  64'(disp_idx),     64'h20);

      // random traffic; upstream never over-dispatches
      for (int c = 0; c < 400; c++) begin
         clr();
         sz = m_q.size();
         k = $urandom_range(W, 0);
         if (k > D - sz) k = D - sz;
         disp(k);
         p = 0;
         last = -1;
         if (sz > 0) begin
            for (int t = 0; t < 3 && p < C; t++) begin
               j = $urandom_range(sz - 1, 0);
               if (j != last && !m_q[j].comp && $urandom_range(2, 0) != 0) begin
                  cmpl(p, (m_head + j) % D, $urandom_range(9, 0) == 0);
                  p++;
                  last = j;
               end
            end
         end
         if (p < C && sz < D && $urandom_range(7, 0) == 0) cmpl(p, (m_head + sz) % D, 1'b1);
         cyc();
      end
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
